pe_group_stream_feeder: RTL and testbench
=========================================

// Module: pe_group_stream_feeder
// PURPOSE
// Transmit-side source for a PE group's W, I and O(bias) input streams. On Start, fetches
// three contiguous word ranges from one shared 1-cycle-latency read port, buffers each
// channel in a small FIFO, and presents them on independent valid/rdy outputs. Sits between
// the on-chip buffer SRAM and the PE group's W_DataIn/I_DataIn/O_DataIn ports.
// PARAMETERS
// DataWidth    32  word width (IEEE-754 single)
// AddrWidth    10  read-port address width
// LenWidth      8  word-count width per channel
// BufferSize    4  FIFO depth per channel (power of 2)
// BufferWidth   2  log2(BufferSize)
// PORTS
// clk              in   1          clock, rising edge
// aclr             in   1          asynchronous reset, active-high
// Start            in   1          launch a transfer; honoured only in IDLE
// W_Base/I_Base/O_Base in AddrWidth start address per channel, sampled at Start
// W_Len/I_Len/O_Len    in LenWidth  words per channel, sampled at Start; 0 = channel unused
// Busy             out  1          high in RUN or DRAIN
// Done             out  1          one-cycle pulse at transfer completion
// Mem_RdEn         out  1          read request
// Mem_Addr         out  AddrWidth  read address
// Mem_RdData       in   DataWidth  read data, valid the cycle after Mem_RdEn
// W_DataOutValid   out  1          W word available;  W_DataOutRdy in 1;  W_DataOut out DataWidth
// I_DataOutValid   out  1          I word available;  I_DataOutRdy in 1;  I_DataOut out DataWidth
// O_DataOutValid   out  1          O word available;  O_DataOutRdy in 1;  O_DataOut out DataWidth
// BEHAVIOUR
// - Reset (aclr=1): state IDLE; all counters, FIFOs, in-flight tag cleared; every output 0.
// - FSM: IDLE -Start-> RUN; RUN -all channels fully issued-> DRAIN;
//   DRAIN -no read in flight & all FIFOs empty-> DONE; DONE -> IDLE (Done=1 for that one cycle).
// - Start in RUN/DRAIN/DONE ignored; Base/Len captured only on the IDLE->RUN edge.
// - All Len=0: IDLE->RUN->DRAIN->DONE->IDLE, no Mem_RdEn, Done 3 cycles after Start.
// - Issue (RUN only, one read/cycle): channel eligible if remaining>0 and
//   fifo_count + inflight < BufferSize. Round-robin W->I->O; pointer moves to the channel after
//   the one granted; no grant leaves pointer unchanged. Mem_RdEn/Mem_Addr combinational from
//   registered state; Mem_Addr = Base + issued_count (wraps modulo 2^AddrWidth).
// - Return: registered tag records granted channel; Mem_RdData pushed into that FIFO at the end
//   of the cycle after Mem_RdEn. Word visible on DataOut with Valid=1 the following cycle
//   (first-word latency Start -> Valid = 3 cycles, uncontended).
// - Handshake: transfer when Valid&Rdy at clock edge; Valid never drops and DataOut never changes
//   until accepted; Valid independent of Rdy. Order within a channel = address order.
// - Full FIFO: credit check forbids overflow; push and pop in same cycle allowed at any count.
// - Empty FIFO: Valid=0; Rdy ignored.
// - Backpressure on one channel never stalls others (its credit blocks only itself).
// - Steady state, one channel only, Rdy=1: one word/cycle after fill.
// - aclr mid-transfer: immediate abort, in-flight return discarded, no Done pulse.
// - Busy=1 in RUN and DRAIN only; 0 in IDLE and DONE.
// TESTING
// 1 W_Base=0x010,W_Len=3, I/O Len=0, all Rdy=1, mem[a]=a -> Mem_Addr 0x010,0x011,0x012 on 3
//   consecutive cycles; W_DataOut 0x10,0x11,0x12 back-to-back; Done once; no I/O Valid.
// 2 W/I/O Len=2 each, bases 0x000/0x100/0x200, Rdy=1 -> issue order W0,I0,O0,W1,I1,O1; each
//   channel delivers its 2 words in order; Done pulse after last pop.
// 3 I_Len=8, I_DataOutRdy=0 for 20 cycles -> exactly 4 reads issued, I_DataOutValid held with
//   first word stable; after Rdy=1 remaining 4 read and all 8 delivered in order.
// 4 All Len=0, Start -> Busy high 2 cycles, Done 3 cycles after Start, no Mem_RdEn.
// 5 Base=0x3FE, Len=4 -> Mem_Addr 0x3FE,0x3FF,0x000,0x001.
// 6 aclr pulse mid-RUN with read in flight -> all outputs 0 next cycle, no Done; new Start runs
//   cleanly from fresh Base/Len.

Source files
------------

// File: rtl/pe_group_stream_feeder.sv
// Streams three contiguous word ranges (W, I, O) from a shared 1-cycle-latency read port
// into per-channel FIFOs, each drained through its own valid/rdy output.
module pe_group_stream_feeder #(
    parameter int DataWidth   = 32,
    parameter int AddrWidth   = 10,
    parameter int LenWidth    = 8,
    parameter int BufferSize  = 4,
    parameter int BufferWidth = 2
) (
    input  logic                 clk,
    input  logic                 aclr,
    input  logic                 Start,
    input  logic [AddrWidth-1:0] W_Base,
    input  logic [AddrWidth-1:0] I_Base,
    input  logic [AddrWidth-1:0] O_Base,
    input  logic [LenWidth-1:0]  W_Len,
    input  logic [LenWidth-1:0]  I_Len,
    input  logic [LenWidth-1:0]  O_Len,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Mem_RdEn,
    output logic [AddrWidth-1:0] Mem_Addr,
    input  logic [DataWidth-1:0] Mem_RdData,
    output logic                 W_DataOutValid,
    input  logic                 W_DataOutRdy,
    output logic [DataWidth-1:0] W_DataOut,
    output logic                 I_DataOutValid,
    input  logic                 I_DataOutRdy,
    output logic [DataWidth-1:0] I_DataOut,
    output logic                 O_DataOutValid,
    input  logic                 O_DataOutRdy,
    output logic [DataWidth-1:0] O_DataOut
);

    localparam int NumCh = 3;

    typedef enum logic [1:0] {stIdle, stRun, stDrain, stDone} stateT;

    stateT state, nextState;

    logic [AddrWidth-1:0]   baseIn [NumCh];
    logic [LenWidth-1:0]    lenIn [NumCh];
    logic [NumCh-1:0]       outRdy;

    logic [AddrWidth-1:0]   base [NumCh];
    logic [LenWidth-1:0]    len [NumCh];
    logic [LenWidth-1:0]    issued [NumCh];
    logic [1:0]             rrPtr;
    logic                   inflightValid;
    logic [1:0]             inflightCh;

    logic [DataWidth-1:0]   fifoMem [NumCh][BufferSize];
    logic [BufferWidth-1:0] rdPtr [NumCh];
    logic [BufferWidth-1:0] wrPtr [NumCh];
    logic [BufferWidth:0]   fifoCount [NumCh];

    logic [NumCh-1:0]       eligible, push, pop, fifoValid;
    logic                   allIssued, allEmpty, grantValid;
    logic [1:0]             grantCh, cand;

    assign baseIn[0] = W_Base;
    assign baseIn[1] = I_Base;
    assign baseIn[2] = O_Base;
    assign lenIn[0]  = W_Len;
    assign lenIn[1]  = I_Len;
    assign lenIn[2]  = O_Len;
    assign outRdy    = {O_DataOutRdy, I_DataOutRdy, W_DataOutRdy};

    // A channel may issue only if the word it requests is guaranteed a FIFO slot on return.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can infer a latch.
        eligible  = '0;
        push      = '0;
        pop       = '0;
        fifoValid = '0;
        allIssued = 1'b1;
        allEmpty  = 1'b1;
        for (int c = 0; c < NumCh; c++) begin
            fifoValid[c] = (fifoCount[c] != '0);
            push[c]      = inflightValid && (inflightCh == 2'(c));
            pop[c]       = fifoValid[c] && outRdy[c];
            eligible[c]  = (state == stRun) && (issued[c] != len[c]) &&
                           (({1'b0, fifoCount[c]} + (BufferWidth+2)'(push[c])) <
                            (BufferWidth+2)'(BufferSize));
            allIssued    = allIssued && (issued[c] == len[c]);
            allEmpty     = allEmpty && !fifoValid[c];
        end
    end

    always_comb begin
        grantValid = 1'b0;
        grantCh    = 2'd0;
        cand       = 2'd0;
        for (int k = 0; k < NumCh; k++) begin
            cand = 2'((int'(rrPtr) + k) % NumCh);
            if (!grantValid && eligible[cand]) begin
                grantValid = 1'b1;
                grantCh    = cand;
            end
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            stIdle:  if (Start) nextState = stRun;
            stRun:   if (allIssued) nextState = stDrain;
            stDrain: if (!inflightValid && allEmpty) nextState = stDone;
            stDone:  nextState = stIdle;
            default: nextState = stIdle;
        endcase
    end

    assign Busy     = (state == stRun) || (state == stDrain);
    assign Done     = (state == stDone);
    assign Mem_RdEn = grantValid;
    assign Mem_Addr = grantValid ? base[grantCh] + AddrWidth'(issued[grantCh]) : '0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state         <= stIdle;
            rrPtr         <= 2'd0;
            inflightValid <= 1'b0;
            inflightCh    <= 2'd0;
            for (int c = 0; c < NumCh; c++) begin
                base[c]      <= '0;
                len[c]       <= '0;
                issued[c]    <= '0;
                rdPtr[c]     <= '0;
                wrPtr[c]     <= '0;
                fifoCount[c] <= '0;
            end
        end else begin
            state         <= nextState;
            inflightValid <= grantValid;
            inflightCh    <= grantCh;
            if (state == stIdle && Start) begin
                rrPtr <= 2'd0;
                for (int c = 0; c < NumCh; c++) begin
                    base[c]   <= baseIn[c];
                    len[c]    <= lenIn[c];
                    issued[c] <= '0;
                end
            end else if (grantValid) begin
                issued[grantCh] <= issued[grantCh] + LenWidth'(1);
                rrPtr           <= (grantCh == 2'd2) ? 2'd0 : grantCh + 2'd1;
            end
            for (int c = 0; c < NumCh; c++) begin
                if (push[c]) wrPtr[c] <= wrPtr[c] + BufferWidth'(1);
                if (pop[c])  rdPtr[c] <= rdPtr[c] + BufferWidth'(1);
                fifoCount[c] <= fifoCount[c] + (BufferWidth+1)'(push[c]) - (BufferWidth+1)'(pop[c]);
            end
        end
    end

    // NOTE: FIFO storage is not reset; the cleared counts guarantee stale words are never shown.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NumCh; c++) begin
            if (push[c]) fifoMem[c][wrPtr[c]] <= Mem_RdData;
        end
    end

    assign W_DataOutValid = fifoValid[0];
    assign I_DataOutValid = fifoValid[1];
    assign O_DataOutValid = fifoValid[2];
    assign W_DataOut      = fifoValid[0] ? fifoMem[0][rdPtr[0]] : '0;
    assign I_DataOut      = fifoValid[1] ? fifoMem[1][rdPtr[1]] : '0;
    assign O_DataOut      = fifoValid[2] ? fifoMem[2][rdPtr[2]] : '0;

endmodule

// File: tb/tb_pe_group_stream_feeder.sv
// Randomised self-checking bench: a queue-based transaction model predicts every output each
// cycle, and directed transfers pin the model with hand-computed literal expectations.
module tb_pe_group_stream_feeder;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int LW = 8;
    localparam int BS = 4;

    logic          clk = 1'b0;
    logic          aclr;
    logic          Start;
    logic [AW-1:0] W_Base, I_Base, O_Base;
    logic [LW-1:0] W_Len, I_Len, O_Len;
    logic          Busy, Done, Mem_RdEn;
    logic [AW-1:0] Mem_Addr;
    logic [DW-1:0] Mem_RdData;
    logic          W_DataOutValid, I_DataOutValid, O_DataOutValid;
    logic          W_DataOutRdy, I_DataOutRdy, O_DataOutRdy;
    logic [DW-1:0] W_DataOut, I_DataOut, O_DataOut;

    always #5 clk = ~clk;

    pe_group_stream_feeder dut (
        .clk(clk), .aclr(aclr), .Start(Start),
        .W_Base(W_Base), .I_Base(I_Base), .O_Base(O_Base),
        .W_Len(W_Len), .I_Len(I_Len), .O_Len(O_Len),
        .Busy(Busy), .Done(Done),
        .Mem_RdEn(Mem_RdEn), .Mem_Addr(Mem_Addr), .Mem_RdData(Mem_RdData),
        .W_DataOutValid(W_DataOutValid), .W_DataOutRdy(W_DataOutRdy), .W_DataOut(W_DataOut),
        .I_DataOutValid(I_DataOutValid), .I_DataOutRdy(I_DataOutRdy), .I_DataOut(I_DataOut),
        .O_DataOutValid(O_DataOutValid), .O_DataOutRdy(O_DataOutRdy), .O_DataOut(O_DataOut)
    );

    logic [2:0]    dutValid;
    logic [DW-1:0] dutData [3];
    assign dutValid   = {O_DataOutValid, I_DataOutValid, W_DataOutValid};
    assign dutData[0] = W_DataOut;
    assign dutData[1] = I_DataOut;
    assign dutData[2] = O_DataOut;

    string chName [3] = '{"W", "I", "O"};

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction model: phase 0 idle, 1 run, 2 drain, 3 done.
    int            mMode;
    int            mBase [3];
    int            mLen [3];
    int            mIssued [3];
    int            mRr;
    int            mInCh;
    int            mInAddr;
    logic [31:0]   mQ [3][$];
    logic [31:0]   salt;

    // Stimulus controls and observation logs.
    bit            startReq, glitchEn;
    logic [AW-1:0] reqBase [3];
    logic [LW-1:0] reqLen [3];
    int            rdyProb [3];
    bit            prevRdEn;
    logic [AW-1:0] prevAddr;
    logic [31:0]   addrLog [$];
    int            addrCyc [$];
    logic [31:0]   acc [3][$];
    int            firstValid [3];
    int            doneCount, doneCyc, busyCount, rdEnCount, lastPopCyc, startCyc;

    function automatic logic [31:0] memWord(input int a);
        return salt ^ 32'(a);
    endfunction

    task automatic modelReset();
        mMode = 0;
        mInCh = -1;
        mRr   = 0;
        for (int c = 0; c < 3; c++) begin
            mQ[c].delete();
            mIssued[c] = 0;
            mLen[c]    = 0;
        end
    endtask

    task automatic clearLogs();
        addrLog.delete();
        addrCyc.delete();
        for (int c = 0; c < 3; c++) begin
            acc[c].delete();
            firstValid[c] = -1;
        end
        doneCount = 0; doneCyc = -1; busyCount = 0; rdEnCount = 0; lastPopCyc = -1;
    endtask

    task automatic modelGrant(output int ch, output int addr);
        ch   = -1;
        addr = 0;
        if (mMode == 1) begin
            for (int k = 0; k < 3; k++) begin
                int c = (mRr + k) % 3;
                if (ch < 0 && mIssued[c] < mLen[c] &&
                    mQ[c].size() + ((mInCh == c) ? 1 : 0) < BS) begin
                    ch   = c;
                    addr = (mBase[c] + mIssued[c]) % (1 << AW);
                end
            end
        end
    endtask

    task automatic checkOutputs();
        int g, ga;
        modelGrant(g, ga);
        check("busy", 32'(Busy), 32'(mMode == 1 || mMode == 2));
        check("done", 32'(Done), 32'(mMode == 3));
        check("rd_en", 32'(Mem_RdEn), 32'(g >= 0));
        if (g >= 0 && Mem_RdEn) check("rd_addr", 32'(Mem_Addr), 32'(ga));
        for (int c = 0; c < 3; c++) begin
            bit v = mQ[c].size() > 0;
            check($sformatf("%s_valid", chName[c]), 32'(dutValid[c]), 32'(v));
            if (v) check($sformatf("%s_data", chName[c]), dutData[c], mQ[c][0]);
            if (dutValid[c] && firstValid[c] < 0) firstValid[c] = cyc;
        end
        if (Mem_RdEn) begin
            addrLog.push_back(32'(Mem_Addr));
            addrCyc.push_back(cyc);
            rdEnCount++;
        end
        if (Done) begin
            doneCount++;
            doneCyc = cyc;
        end
        if (Busy) busyCount++;
    endtask

    task automatic modelStep();
        int  g, ga, newMode;
        bit  rdy [3];
        bit  allIssued = 1;
        bit  allEmpty  = 1;
        rdy[0] = W_DataOutRdy; rdy[1] = I_DataOutRdy; rdy[2] = O_DataOutRdy;
        modelGrant(g, ga);
        for (int c = 0; c < 3; c++) begin
            if (mIssued[c] != mLen[c]) allIssued = 0;
            if (mQ[c].size() != 0) allEmpty = 0;
        end
        newMode = mMode;
        case (mMode)
            0: if (Start) begin
                newMode = 1;
                mRr     = 0;
                mBase[0] = W_Base; mBase[1] = I_Base; mBase[2] = O_Base;
                mLen[0]  = W_Len;  mLen[1]  = I_Len;  mLen[2]  = O_Len;
                for (int c = 0; c < 3; c++) mIssued[c] = 0;
            end
            1: if (allIssued) newMode = 2;
            2: if (mInCh < 0 && allEmpty) newMode = 3;
            default: newMode = 0;
        endcase
        for (int c = 0; c < 3; c++)
            if (mQ[c].size() > 0 && rdy[c]) void'(mQ[c].pop_front());
        if (mInCh >= 0) mQ[mInCh].push_back(memWord(mInAddr));
        mInCh   = g;
        mInAddr = ga;
        if (g >= 0) begin
            mIssued[g]++;
            mRr = (g + 1) % 3;
        end
        mMode = newMode;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        checkOutputs();
        Mem_RdData = prevRdEn ? memWord(int'(prevAddr)) : '0;
        prevRdEn   = Mem_RdEn;
        prevAddr   = Mem_Addr;
        if (startReq) begin
            Start  = 1'b1;
            W_Base = reqBase[0]; I_Base = reqBase[1]; O_Base = reqBase[2];
            W_Len  = reqLen[0];  I_Len  = reqLen[1];  O_Len  = reqLen[2];
            startReq = 0;
        end else if (glitchEn && mMode != 0) begin
            Start  = ($urandom_range(7) == 0);
            W_Base = AW'($urandom); I_Base = AW'($urandom); O_Base = AW'($urandom);
            W_Len  = LW'($urandom); I_Len  = LW'($urandom); O_Len  = LW'($urandom);
        end else begin
            Start = 1'b0;
        end
        W_DataOutRdy = ($urandom_range(99) < rdyProb[0]);
        I_DataOutRdy = ($urandom_range(99) < rdyProb[1]);
        O_DataOutRdy = ($urandom_range(99) < rdyProb[2]);
        if (W_DataOutValid && W_DataOutRdy) begin acc[0].push_back(W_DataOut); lastPopCyc = cyc; end
        if (I_DataOutValid && I_DataOutRdy) begin acc[1].push_back(I_DataOut); lastPopCyc = cyc; end
        if (O_DataOutValid && O_DataOutRdy) begin acc[2].push_back(O_DataOut); lastPopCyc = cyc; end
        modelStep();
    endtask

    task automatic startTransfer(input logic [AW-1:0] wb, input logic [AW-1:0] ib,
                                 input logic [AW-1:0] ob, input logic [LW-1:0] wl,
                                 input logic [LW-1:0] il, input logic [LW-1:0] ol);
        clearLogs();
        reqBase[0] = wb; reqBase[1] = ib; reqBase[2] = ob;
        reqLen[0]  = wl; reqLen[1]  = il; reqLen[2]  = ol;
        startReq = 1;
        tick();
        startCyc = cyc;
    endtask

    task automatic waitIdle(input int maxCyc);
        int n = 0;
        while (mMode != 0 && n < maxCyc) begin
            tick();
            n++;
        end
        check("idle_bound", 32'(n < maxCyc), 32'd1);
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_busy"}, 32'(Busy), 0);
        check({tag, "_done"}, 32'(Done), 0);
        check({tag, "_rden"}, 32'(Mem_RdEn), 0);
        check({tag, "_addr"}, 32'(Mem_Addr), 0);
        check({tag, "_valid"}, 32'(dutValid), 0);
        check({tag, "_wdata"}, W_DataOut, 0);
        check({tag, "_idata"}, I_DataOut, 0);
        check({tag, "_odata"}, O_DataOut, 0);
    endtask

    initial begin
        aclr = 1'b1; Start = 1'b0; Mem_RdData = '0;
        W_Base = '0; I_Base = '0; O_Base = '0; W_Len = '0; I_Len = '0; O_Len = '0;
        W_DataOutRdy = 1'b0; I_DataOutRdy = 1'b0; O_DataOutRdy = 1'b0;
        startReq = 0; glitchEn = 0; prevRdEn = 0; prevAddr = '0; salt = '0;
        for (int c = 0; c < 3; c++) rdyProb[c] = 100;
        modelReset();
        clearLogs();
        tick();
        tick();
        checkAllZero("reset");
        aclr = 1'b0;
        tick();

        // Single W channel, back-to-back issue and delivery.
        startTransfer(10'h010, 10'h0, 10'h0, 8'd3, 8'd0, 8'd0);
        waitIdle(200);
        tick(); tick();
        check("t1_nreads", addrLog.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t1_addr%0d", i), addrLog[i], 32'h10 + i);
            check($sformatf("t1_wdata%0d", i), acc[0][i], 32'h10 + i);
        end
        check("t1_consecutive", addrCyc[2] - addrCyc[0], 2);
        check("t1_latency", firstValid[0] - startCyc, 3);
        check("t1_io_words", acc[1].size() + acc[2].size(), 0);
        check("t1_done_count", doneCount, 1);

        // Round-robin over three channels.
        startTransfer(10'h000, 10'h100, 10'h200, 8'd2, 8'd2, 8'd2);
        waitIdle(200);
        tick(); tick();
        begin
            logic [31:0] expA [6];
            expA = '{32'h000, 32'h100, 32'h200, 32'h001, 32'h101, 32'h201};
            check("t2_nreads", addrLog.size(), 6);
            for (int i = 0; i < 6; i++) check($sformatf("t2_addr%0d", i), addrLog[i], expA[i]);
        end
        check("t2_o_last", acc[2][1], 32'h201);
        check("t2_done_after_pop", doneCyc - lastPopCyc, 2);
        check("t2_done_count", doneCount, 1);

        // Backpressure on I: credit stops issue at FIFO depth.
        rdyProb[1] = 0;
        startTransfer(10'h0, 10'h040, 10'h0, 8'd0, 8'd8, 8'd0);
        repeat (20) tick();
        check("t3_reads_blocked", addrLog.size(), 4);
        check("t3_hold_valid", 32'(I_DataOutValid), 1);
        check("t3_hold_data", I_DataOut, 32'h40);
        rdyProb[1] = 100;
        waitIdle(200);
        check("t3_nwords", acc[1].size(), 8);
        for (int i = 0; i < 8; i++) check($sformatf("t3_idata%0d", i), acc[1][i], 32'h40 + i);

        // Empty transfer.
        startTransfer(10'h0, 10'h0, 10'h0, 8'd0, 8'd0, 8'd0);
        waitIdle(50);
        tick(); tick();
        check("t4_done_latency", doneCyc - startCyc, 3);
        check("t4_busy_cycles", busyCount, 2);
        check("t4_no_reads", rdEnCount, 0);

        // Address wrap.
        startTransfer(10'h3FE, 10'h0, 10'h0, 8'd4, 8'd0, 8'd0);
        waitIdle(100);
        begin
            logic [31:0] expW [4];
            expW = '{32'h3FE, 32'h3FF, 32'h000, 32'h001};
            for (int i = 0; i < 4; i++) begin
                check($sformatf("t5_addr%0d", i), addrLog[i], expW[i]);
                check($sformatf("t5_wdata%0d", i), acc[0][i], expW[i]);
            end
        end

        // Abort mid-run with a read in flight, then a clean restart.
        salt = 32'hA5A5_0000;
        startTransfer(10'h050, 10'h150, 10'h250, 8'd6, 8'd5, 8'd7);
        begin
            int n = 0;
            while (!(mMode == 1 && mInCh >= 0) && n < 20) begin tick(); n++; end
            check("t6_inflight_seen", 32'(n < 20), 1);
        end
        aclr = 1'b1;
        modelReset();
        clearLogs();
        tick();
        checkAllZero("abort");
        tick();
        aclr = 1'b0;
        tick(); tick();
        check("t6_no_done", doneCount, 0);
        startTransfer(10'h123, 10'h0F0, 10'h3F0, 8'd3, 8'd4, 8'd2);
        waitIdle(200);
        check("t6_w_words", acc[0].size(), 3);
        check("t6_i_words", acc[1].size(), 4);
        check("t6_o_words", acc[2].size(), 2);
        check("t6_w_first", acc[0][0], 32'hA5A5_0123);
        check("t6_done_count", doneCount, 1);

        // Randomised transfers with random backpressure and ignored Start pulses.
        for (int t = 0; t < 25; t++) begin
            logic [LW-1:0] l [3];
            salt = $urandom;
            for (int c = 0; c < 3; c++) begin
                l[c]       = LW'($urandom_range(12));
                rdyProb[c] = $urandom_range(100, 10);
            end
            glitchEn = 1;
            startTransfer(AW'($urandom), AW'($urandom), AW'($urandom), l[0], l[1], l[2]);
            waitIdle(3000);
            glitchEn = 0;
            tick();
            for (int c = 0; c < 3; c++)
                check($sformatf("rnd%0d_%s_words", t, chName[c]), acc[c].size(), 32'(l[c]));
            check($sformatf("rnd%0d_done_count", t), doneCount, 1);
        end

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
